mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single-port 16x16 memory (rd_en/wr_en/addr/wdata/rdata) between NUM_REQ requesters.
- Round-robin arbitration, one access outstanding at a time; sequences read latency and returns read data with a per-requester ack pulse.
- Sits between requester agents/engines and the memory, and drives the same signals the memory driver modport drives.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
AW, 4, address width
DW, 16, data width
RD_LAT, 1, cycles from mem_rd_en cycle to valid mem_rdata (1..4)

Ports:
clk  input  1  clock, all logic on posedge
reset  input  1  synchronous, active-low reset
req  input  NUM_REQ  request per requester, held until ack
req_we  input  NUM_REQ  1=write, 0=read, per requester
req_addr  input  NUM_REQ*AW  packed addresses, requester i at [i*AW +: AW]
req_wdata  input  NUM_REQ*DW  packed write data, requester i at [i*DW +: DW]
ack  output  NUM_REQ  one-cycle completion pulse, onehot0
rsp_rdata  output  DW  read data, valid in ack cycle of a read
mem_wr_en  output  1  memory write enable
mem_rd_en  output  1  memory read enable
mem_addr  output  AW  memory address
mem_wdata  output  DW  memory write data
mem_rdata  input  DW  memory read data

Behaviour:
- Reset: sampled low at posedge (clk and reset only, synchronous, active-low) -> state IDLE, all outputs 0, rr pointer 0, latched command cleared. Reset mid-operation abandons the access; mem enables deassert at the same edge, and no ack is issued.
- All outputs come from flops or from state/winner decode. No combinational path from req* to any output.
- FSM states:
  - IDLE: if |req, select winner by round-robin, latch we/addr/wdata/index, go to ISSUE. Otherwise stay.
  - ISSUE (1 cycle): mem_wr_en=we or mem_rd_en=~we. mem_addr/mem_wdata = latched values. Write goes to RESP; read goes to WAIT with count=RD_LAT-1.
  - WAIT: enables 0. When count==0, capture mem_rdata into rdata reg and go to RESP; else decrement.
  - RESP (1 cycle): ack[winner]=1. rsp_rdata = captured data for reads (holds its last value otherwise). rr pointer = winner+1 mod NUM_REQ. Go to IDLE.
- Latency from req seen in IDLE to ack:
  - Write: ack on 2nd cycle after (IDLE->ISSUE->RESP).
  - Read: ack on (2+RD_LAT)th cycle after.
- Throughput: one access per 3 cycles (write) or 3+RD_LAT cycles (read).
- Round-robin: search starts at the pointer index and takes the first set req bit, wrapping from NUM_REQ-1 to 0. After reset, requester 0 has highest priority.
- Command is latched at grant. Later changes to req_addr/req_wdata/req_we do not affect the pending access.
- If a requester drops req before its ack, the access still completes and ack still pulses.
- A requester must deassert req in the cycle after ack. If req is still high in IDLE, it is treated as a new request.
- Simultaneous requests: exactly one winner; the others wait, with no loss.
- mem_addr/mem_wdata retain their last values outside ISSUE. Only the enables qualify them.

Optional Feature:
MEM_ARB_STATS_EN
- Defined: adds outputs stat_xfer_cnt[15:0] and stat_conflict_cnt[15:0].
  - stat_xfer_cnt: completed accesses, +1 per RESP.
  - stat_conflict_cnt: IDLE cycles where popcount(req)>1.
  - Both counters saturate at 16'hFFFF and clear on reset.
- Undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Package mem_arb_pkg: state enum (IDLE, ISSUE, WAIT, RESP), default AW=4 and DW=16 constants, and a latched-command struct type (we, addr, wdata, index).
- Sub-module mem_arb_rr: combinational round-robin picker (inputs req vector and pointer; outputs onehot grant and index, plus a valid flag). Instantiated once.

Test Plan:
- Reset mid-read (RD_LAT=1): requester 0 read addr 4'h3, reset low during WAIT -> no ack, enables 0, next req from requester 1 granted first (pointer 0 but only req1 active).
- Single write: req[0]=1, we=1, addr 4'h5, wdata 16'hA5A5 -> mem_wr_en=1 with addr 5/data A5A5 exactly 1 cycle later, ack[0] 2 cycles after request seen.
- Read-back: requester 1 reads addr 4'h5 after the write -> mem_rd_en 1 cycle, ack[1] at cycle 3, rsp_rdata=16'hA5A5.
- Contention: req=2'b11 continuously (writes to addr 1 and 2) -> grants alternate 0,1,0,1; no requester starves; 4 acks in 12 cycles.
- Command stability: requester 0 changes req_addr from 4'h7 to 4'h9 during ISSUE -> memory sees 4'h7 only.
- RD_LAT=3, NUM_REQ=4, reqs 4'b1010 -> requester 1 then 3 are served; each read acks 5 cycles after grant. With MEM_ARB_STATS_EN: stat_xfer_cnt=2 and stat_conflict_cnt equal to the number of IDLE cycles with 2 active requests.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory arbiter.
package mem_arb_pkg;

    localparam int unsigned MEM_ARB_AW = 4;
    localparam int unsigned MEM_ARB_DW = 16;
    localparam int unsigned MEM_ARB_IW = 3;
    localparam int unsigned MEM_ARB_CW = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } mem_arb_state_e;

    // Command captured at grant; index is wide enough for up to 8 requesters.
    typedef struct packed {
        logic                  we;
        logic [MEM_ARB_AW-1:0] addr;
        logic [MEM_ARB_DW-1:0] wdata;
        logic [MEM_ARB_IW-1:0] index;
    } mem_arb_cmd_t;

endpackage

// File: rtl/mem_arb_rr.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module mem_arb_rr #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IW      = 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IW-1:0]      i_ptr,
    output logic [NUM_REQ-1:0] o_gnt_c,
    output logic [IW-1:0]      o_idx_c,
    output logic               o_valid_c
);

    always_comb begin
        o_gnt_c   = '0;
        o_idx_c   = '0;
        o_valid_c = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            int unsigned w_j;
            w_j = (32'(i_ptr) + i) % NUM_REQ;
            if (!o_valid_c && i_req[w_j]) begin
                o_valid_c    = 1'b1;
                o_gnt_c[w_j] = 1'b1;
                o_idx_c      = IW'(w_j);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory among NUM_REQ requesters.
// Optional MEM_ARB_STATS_EN adds saturating transfer/conflict counters.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned AW      = MEM_ARB_AW,
    parameter int unsigned DW      = MEM_ARB_DW,
    parameter int unsigned RD_LAT  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    req_we,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*DW-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    ack,
    output logic [DW-1:0]         rsp_rdata,
    output logic                  mem_wr_en,
    output logic                  mem_rd_en,
    output logic [AW-1:0]         mem_addr,
    output logic [DW-1:0]         mem_wdata,
    input  logic [DW-1:0]         mem_rdata
`ifdef MEM_ARB_STATS_EN
   ,output logic [15:0]           stat_xfer_cnt,
    output logic [15:0]           stat_conflict_cnt
`endif
);

    localparam int unsigned IW = $clog2(NUM_REQ);

    mem_arb_state_e          r_state;
    mem_arb_state_e          w_state_nxt;
    mem_arb_cmd_t            r_cmd;
    logic [IW-1:0]           r_ptr;
    logic [IW-1:0]           w_ptr_nxt;
    logic [MEM_ARB_CW-1:0]   r_cnt;
    logic [MEM_ARB_CW-1:0]   w_cnt_nxt;
    logic [DW-1:0]           r_rdata;
    logic                    w_grant;
    logic                    w_capture;
    logic [NUM_REQ-1:0]      w_rr_gnt;
    logic [IW-1:0]           w_rr_idx;
    logic                    w_rr_valid;
    logic                    w_sel_we;
    logic [AW-1:0]           w_sel_addr;
    logic [DW-1:0]           w_sel_wdata;

    mem_arb_rr #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr (
        .i_req     (req),
        .i_ptr     (r_ptr),
        .o_gnt_c   (w_rr_gnt),
        .o_idx_c   (w_rr_idx),
        .o_valid_c (w_rr_valid)
    );

    // Mux the winning requester's command fields.
    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_rr_gnt[i]) begin
                w_sel_we    = req_we[i];
                w_sel_addr  = req_addr[i*AW +: AW];
                w_sel_wdata = req_wdata[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_grant     = 1'b0;
        w_capture   = 1'b0;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            IDLE: begin
                if (w_rr_valid) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (r_cmd.we) begin
                    w_state_nxt = RESP;
                end else begin
                    w_state_nxt = WAIT;
                    w_cnt_nxt   = MEM_ARB_CW'(RD_LAT - 1);
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
                if (r_cmd.index == MEM_ARB_IW'(NUM_REQ - 1)) w_ptr_nxt = '0;
                else                                         w_ptr_nxt = IW'(r_cmd.index + 1'b1);
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cmd   <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_rdata <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_ptr <= w_ptr_nxt;
            if (w_grant) begin
                r_cmd <= '{we:    w_sel_we,
                           addr:  MEM_ARB_AW'(w_sel_addr),
                           wdata: MEM_ARB_DW'(w_sel_wdata),
                           index: MEM_ARB_IW'(w_rr_idx)};
            end
            if (w_capture) r_rdata <= mem_rdata;
        end
    end

    // Enables and ack decode from state; address/data hold the latched command.
    assign mem_wr_en = (r_state == ISSUE) &&  r_cmd.we;
    assign mem_rd_en = (r_state == ISSUE) && !r_cmd.we;
    assign mem_addr  = AW'(r_cmd.addr);
    assign mem_wdata = DW'(r_cmd.wdata);
    assign ack       = (r_state == RESP) ? (NUM_REQ'(1) << r_cmd.index) : '0;
    assign rsp_rdata = r_rdata;

`ifdef MEM_ARB_STATS_EN
    logic [15:0] r_xfer_cnt;
    logic [15:0] r_conflict_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_xfer_cnt     <= '0;
            r_conflict_cnt <= '0;
        end else begin
            if (r_state == RESP && r_xfer_cnt != 16'hFFFF)
                r_xfer_cnt <= r_xfer_cnt + 16'd1;
            if (r_state == IDLE && $countones(req) > 1 && r_conflict_cnt != 16'hFFFF)
                r_conflict_cnt <= r_conflict_cnt + 16'd1;
        end
    end

    assign stat_xfer_cnt     = r_xfer_cnt;
    assign stat_conflict_cnt = r_conflict_cnt;
`endif

endmodule
